seq_stream_ctrl: RTL and testbench

Test-sequencing controller for the serial sequence-detector datapath (1-bit `in`, `clk`, `reset`, 1-bit `out`).
- On a start request it clears the detector and serialises a programmed bit pattern into the detector's input, one bit per clock, MSB-first.
- It samples the detector's match output and reports hit count, first-hit position and completion.
- It sits between the board-level control logic (switch/button capture) and the detector instance.

---
 rtl/seq_stream_ctrl.sv | 114 +++++++++++
 tb/tb_seq_stream_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_ctrl.sv
// Test sequencer for a serial sequence detector: clears it, shifts a pattern in MSB-first,
// and collects hit count / first-hit position from the detector's match output.
module seq_stream_ctrl #(
    parameter int WORD_W  = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8,
    parameter int DET_LAT = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [WORD_W-1:0] i_word_in,
    input  logic [LEN_W-1:0]  i_len_in,
    output logic              o_det_in,
    output logic              o_det_reset,
    input  logic              i_det_out,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_hit_count,
    output logic              o_hit_any,
    output logic [LEN_W-1:0]  o_first_hit_pos
);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_SHIFT, S_FLUSH, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [WORD_W-1:0]  r_shift, w_shift_nxt;
    logic [LEN_W-1:0]   r_len, r_k, w_k_nxt, r_k_d;
    logic               r_slot_d;
    logic               w_len_ok, w_accept, w_reject, w_slot;
    logic [LEN_W-1:0]   w_slot_k;

    assign w_len_ok = (i_len_in != '0) && (i_len_in <= LEN_W'(WORD_W));
    assign w_accept = (r_state == S_IDLE) && i_start && w_len_ok;
    assign w_reject = (r_state == S_IDLE) && i_start && !w_len_ok;

    // With a Moore detector the match for bit k shows up one cycle late, so the slot is delayed too.
    assign w_slot   = (DET_LAT == 0) ? (r_state == S_SHIFT) : r_slot_d;
    assign w_slot_k = (DET_LAT == 0) ? r_k : r_k_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CLR;
                    w_shift_nxt = i_word_in << (LEN_W'(WORD_W) - i_len_in);
                    w_k_nxt     = '0;
                end
            end
            S_CLR: begin
                w_state_nxt = S_SHIFT;
                w_k_nxt     = LEN_W'(1);
            end
            S_SHIFT: begin
                w_shift_nxt = r_shift << 1;
                if (r_k == r_len) w_state_nxt = (DET_LAT == 1) ? S_FLUSH : S_DONE;
                else              w_k_nxt     = r_k + LEN_W'(1);
            end
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift     <= '0;
            r_len       <= '0;
            r_k         <= '0;
            r_k_d       <= '0;
            r_slot_d    <= 1'b0;
            o_det_in    <= 1'b0;
            o_det_reset <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_k         <= w_k_nxt;
            r_k_d       <= r_k;
            r_slot_d    <= (r_state == S_SHIFT);
            if (w_accept) r_len <= i_len_in;
            // Outputs are decoded from the next state so they are clean flops aligned with the state.
            o_det_in    <= (w_state_nxt == S_SHIFT) ? w_shift_nxt[WORD_W-1] : 1'b0;
            o_det_reset <= (w_state_nxt == S_CLR);
            o_busy      <= (w_state_nxt == S_CLR) || (w_state_nxt == S_SHIFT) ||
                           (w_state_nxt == S_FLUSH);
            o_done      <= (w_state_nxt == S_DONE);
            o_err       <= w_reject;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || w_accept) begin
            o_hit_count     <= '0;
            o_hit_any       <= 1'b0;
            o_first_hit_pos <= '0;
        end else if (w_slot && i_det_out) begin
            if (o_hit_count != '1) o_hit_count <= o_hit_count + CNT_W'(1);
            o_hit_any <= 1'b1;
            if (!o_hit_any) o_first_hit_pos <= w_slot_k;
        end
    end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Directed bench: Mealy and Moore "1011" detector models plus a stuck-at-1 detector
// drive three controller instances; expected values are hand-derived.
module tb_seq_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] word = '0;
    logic [4:0]  len = '0;
    logic [2:0]  start_v = '0;
    logic        clr_inject = 1'b0;
    int          sel = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    logic       a_din, a_drst, a_dout, a_busy, a_done, a_err, a_any;
    logic [7:0] a_cnt;
    logic [4:0] a_pos;
    logic       b_din, b_drst, b_dout, b_busy, b_done, b_err, b_any;
    logic [7:0] b_cnt;
    logic [4:0] b_pos;
    logic       c_din, c_drst, c_busy, c_done, c_err, c_any;
    logic [2:0] c_cnt;
    logic [4:0] c_pos;

    seq_stream_ctrl #(.WORD_W(16), .LEN_W(5), .CNT_W(8), .DET_LAT(0)) u_mealy (
        .i_clk(clk), .i_reset(reset), .i_start(start_v[0]), .i_word_in(word), .i_len_in(len),
        .o_det_in(a_din), .o_det_reset(a_drst), .i_det_out(a_dout), .o_busy(a_busy),
        .o_done(a_done), .o_err(a_err), .o_hit_count(a_cnt), .o_hit_any(a_any),
        .o_first_hit_pos(a_pos));

    seq_stream_ctrl #(.WORD_W(16), .LEN_W(5), .CNT_W(8), .DET_LAT(1)) u_moore (
        .i_clk(clk), .i_reset(reset), .i_start(start_v[1]), .i_word_in(word), .i_len_in(len),
        .o_det_in(b_din), .o_det_reset(b_drst), .i_det_out(b_dout), .o_busy(b_busy),
        .o_done(b_done), .o_err(b_err), .o_hit_count(b_cnt), .o_hit_any(b_any),
        .o_first_hit_pos(b_pos));

    seq_stream_ctrl #(.WORD_W(16), .LEN_W(5), .CNT_W(3), .DET_LAT(0)) u_sat (
        .i_clk(clk), .i_reset(reset), .i_start(start_v[2]), .i_word_in(word), .i_len_in(len),
        .o_det_in(c_din), .o_det_reset(c_drst), .i_det_out(1'b1), .o_busy(c_busy),
        .o_done(c_done), .o_err(c_err), .o_hit_count(c_cnt), .o_hit_any(c_any),
        .o_first_hit_pos(c_pos));

    // overlapping "1011": S0 none, S1 "1", S2 "10", S3 "101"
    function automatic logic [1:0] f_nxt(input logic [1:0] st, input logic b);
        case (st)
            2'd0:    return b ? 2'd1 : 2'd0;
            2'd1:    return b ? 2'd1 : 2'd2;
            2'd2:    return b ? 2'd3 : 2'd0;
            default: return b ? 2'd1 : 2'd2;
        endcase
    endfunction

    logic [1:0] ma_st, mb_st;
    logic       mb_out;
    always @(posedge clk) begin
        if (reset || a_drst) ma_st <= 2'd0;
        else                 ma_st <= f_nxt(ma_st, a_din);
        if (reset || b_drst) begin
            mb_st  <= 2'd0;
            mb_out <= 1'b0;
        end else begin
            mb_st  <= f_nxt(mb_st, b_din);
            mb_out <= (mb_st == 2'd3) && b_din;
        end
    end
    assign a_dout = (ma_st == 2'd3) && a_din;
    assign b_dout = mb_out | (clr_inject & b_drst);

    logic       m_din, m_drst, m_busy, m_done, m_err, m_any;
    logic [7:0] m_cnt;
    logic [4:0] m_pos;
    always_comb begin
        m_din = a_din; m_drst = a_drst; m_busy = a_busy; m_done = a_done;
        m_err = a_err; m_any = a_any; m_cnt = a_cnt; m_pos = a_pos;
        if (sel == 1) begin
            m_din = b_din; m_drst = b_drst; m_busy = b_busy; m_done = b_done;
            m_err = b_err; m_any = b_any; m_cnt = b_cnt; m_pos = b_pos;
        end else if (sel == 2) begin
            m_din = c_din; m_drst = c_drst; m_busy = c_busy; m_done = c_done;
            m_err = c_err; m_any = c_any; m_cnt = {5'd0, c_cnt}; m_pos = c_pos;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_results(input string tag, input int hit, input int pos);
        chk({tag, " hit_count"}, 32'(m_cnt), 32'(hit));
        chk({tag, " hit_any"}, 32'(m_any), 32'(hit != 0));
        chk({tag, " first_hit_pos"}, 32'(m_pos), 32'(pos));
    endtask

    task automatic run(input string tag, input int s, input logic [15:0] w, input int L,
                       input int D, input int hit, input int pos);
        @(negedge clk);
        sel = s; word = w; len = L[4:0]; start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        for (int c = 1; c <= L + D + 2; c++) begin
            chk($sformatf("%s busy c%0d", tag, c), 32'(m_busy), 32'(c <= L + D + 1));
            chk($sformatf("%s done c%0d", tag, c), 32'(m_done), 32'(c == L + D + 2));
            chk($sformatf("%s det_reset c%0d", tag, c), 32'(m_drst), 32'(c == 1));
            chk($sformatf("%s det_in c%0d", tag, c), 32'(m_din),
                32'((c >= 2 && c <= L + 1) ? w[L + 1 - c] : 1'b0));
            @(negedge clk);
        end
        chk({tag, " done after"}, 32'(m_done), 32'd0);
        chk({tag, " busy after"}, 32'(m_busy), 32'd0);
        chk_results(tag, hit, pos);
    endtask

    task automatic bad_len(input logic [4:0] l);
        @(negedge clk);
        sel = 0; len = l; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk($sformatf("err pulse len%0d", l), 32'(a_err), 32'd1);
        chk($sformatf("err busy len%0d", l), 32'(a_busy), 32'd0);
        @(negedge clk);
        chk($sformatf("err clear len%0d", l), 32'(a_err), 32'd0);
        chk($sformatf("err busy2 len%0d", l), 32'(a_busy), 32'd0);
        chk_results($sformatf("err len%0d", l), 2, 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst det_in", 32'(a_din), 32'd0);
        chk("rst det_reset", 32'(a_drst), 32'd0);
        chk("rst busy", 32'(a_busy), 32'd0);
        chk("rst done", 32'(a_done), 32'd0);
        chk("rst err", 32'(a_err), 32'd0);
        chk_results("rst", 0, 0);
        reset = 1'b0;

        run("mealy", 0, 16'b1011011, 7, 0, 2, 4);
        bad_len(5'd0);
        bad_len(5'd17);

        clr_inject = 1'b1;
        run("moore", 1, 16'b1011, 4, 1, 1, 4);
        clr_inject = 1'b0;

        run("sat", 2, 16'hFFFF, 16, 0, 7, 1);

        // abort during SHIFT k=3 (cycle 4)
        @(negedge clk);
        sel = 0; word = 16'b1011011; len = 5'd7; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort pre busy", 32'(a_busy), 32'd1);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort rst busy", 32'(a_busy), 32'd0);
            chk("abort rst det_in", 32'(a_din), 32'd0);
            chk("abort rst det_reset", 32'(a_drst), 32'd0);
            chk("abort rst done", 32'(a_done), 32'd0);
            chk_results("abort rst", 0, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort post done", 32'(a_done), 32'd0);
            chk("abort post busy", 32'(a_busy), 32'd0);
        end
        chk_results("abort post", 0, 0);
        run("rerun", 0, 16'b10110, 5, 0, 1, 4);

        // start held: period is CLR, SHIFT, SHIFT, DONE, IDLE
        @(negedge clk);
        sel = 0; word = 16'b11; len = 5'd2; start_v[0] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            chk($sformatf("held busy c%0d", c), 32'(a_busy), 32'((c % 5) >= 1 && (c % 5) <= 3));
            chk($sformatf("held done c%0d", c), 32'(a_done), 32'((c % 5) == 4));
            chk($sformatf("held err c%0d", c), 32'(a_err), 32'd0);
        end
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("held end busy", 32'(a_busy), 32'd0);
        chk_results("held", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
